// File: rtl/count_tracker_pkg.sv
// Shared types and constants for the count_tracker monitor and its step classifier.
`default_nettype none

package count_tracker_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;
    localparam logic [1:0] DIR_ILL  = 2'b11;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

endpackage

`default_nettype wire

// File: rtl/count_tracker_step_classifier.sv
// step_classifier: combinational classification of one observed count transition.
`default_nettype none

module step_classifier
    import count_tracker_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] last_i,
    input  logic [WIDTH-1:0] count_i,
    output logic [1:0]       dir_o,
    output logic             wrap_up_o,
    output logic             wrap_dn_o
);

    logic [WIDTH-1:0] delta;

    always_comb begin
        delta     = count_i - last_i;
        dir_o     = DIR_ILL;
        wrap_up_o = 1'b0;
        wrap_dn_o = 1'b0;
        // Up-step is tested before down-step so a 1-bit bus reads +1 as up.
        if (delta == '0) begin
            dir_o = DIR_HOLD;
        end else if (delta == WIDTH'(1)) begin
            dir_o     = DIR_UP;
            wrap_up_o = &last_i;
        end else if (&delta) begin
            dir_o     = DIR_DN;
            wrap_dn_o = (last_i == '0);
        end
    end

endmodule

`default_nettype wire

// File: rtl/count_tracker.sv
// count_tracker: decodes an observed up/down count bus into steps and an extended
// position, tracking lock and declaring FAULT after repeated illegal jumps.
`default_nettype none

module count_tracker
    import count_tracker_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int EXT_WIDTH = 8,
    parameter int ERR_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_valid,
    input  logic [WIDTH-1:0]     count_in,
    input  logic                 clear,
    output logic [EXT_WIDTH-1:0] position,
    output logic [1:0]           dir,
    output logic                 step_valid,
    output logic                 wrap_up,
    output logic                 wrap_dn,
    output logic                 err,
    output logic                 locked,
    output logic [7:0]           err_cnt
);

    localparam logic [3:0] C_ERR_LIMIT = 4'(ERR_LIMIT);

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      last_q, last_d;
    logic [EXT_WIDTH-1:0]  pos_q, pos_d;
    logic [1:0]            dir_q, dir_d;
    logic                  step_q, step_d;
    logic                  wrap_up_q, wrap_up_d;
    logic                  wrap_dn_q, wrap_dn_d;
    logic                  err_q, err_d;
    logic                  locked_q, locked_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic [3:0]            cons_q, cons_d;

    logic [1:0]            w_dir;
    logic                  w_wrap_up;
    logic                  w_wrap_dn;

    step_classifier #(.WIDTH(WIDTH)) u_step_classifier (
        .last_i    (last_q),
        .count_i   (count_in),
        .dir_o     (w_dir),
        .wrap_up_o (w_wrap_up),
        .wrap_dn_o (w_wrap_dn)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        wrap_up_d = 1'b0;
        wrap_dn_d = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        cons_d    = cons_q;

        // clear discards any coincident sample; position/dir/last are kept.
        if (clear) begin
            state_d   = UNLOCKED;
            err_cnt_d = '0;
            cons_d    = '0;
        end else if (sample_valid) begin
            case (state_q)
                UNLOCKED: begin
                    last_d  = count_in;
                    pos_d   = {{(EXT_WIDTH-WIDTH){1'b0}}, count_in};
                    dir_d   = DIR_HOLD;
                    step_d  = 1'b1;
                    state_d = LOCKED;
                end
                LOCKED: begin
                    last_d = count_in;
                    dir_d  = w_dir;
                    step_d = 1'b1;
                    if (w_dir == DIR_ILL) begin
                        err_d = 1'b1;
                        if (err_cnt_q != ERR_CNT_MAX) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                        cons_d = cons_q + 4'd1;
                        if (cons_q + 4'd1 == C_ERR_LIMIT) begin
                            state_d = FAULT;
                        end
                    end else begin
                        cons_d = '0;
                        if (w_dir == DIR_UP) begin
                            pos_d     = pos_q + EXT_WIDTH'(1);
                            wrap_up_d = w_wrap_up;
                        end else if (w_dir == DIR_DN) begin
                            pos_d     = pos_q - EXT_WIDTH'(1);
                            wrap_dn_d = w_wrap_dn;
                        end
                    end
                end
                default: ;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= UNLOCKED;
            last_q    <= '0;
            pos_q     <= '0;
            dir_q     <= DIR_HOLD;
            step_q    <= 1'b0;
            wrap_up_q <= 1'b0;
            wrap_dn_q <= 1'b0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
            err_cnt_q <= '0;
            cons_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            wrap_up_q <= wrap_up_d;
            wrap_dn_q <= wrap_dn_d;
            err_q     <= err_d;
            locked_q  <= locked_d;
            err_cnt_q <= err_cnt_d;
            cons_q    <= cons_d;
        end
    end

    assign position   = pos_q;
    assign dir        = dir_q;
    assign step_valid = step_q;
    assign wrap_up    = wrap_up_q;
    assign wrap_dn    = wrap_dn_q;
    assign err        = err_q;
    assign locked     = locked_q;
    assign err_cnt    = err_cnt_q;

endmodule

`default_nettype wire
